// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: pads a word-streamed message to SHA-256 blocks and replays each block
// as 16 back-to-back words with a start pulse for the core.
module sha256_msg_padder #(
    parameter int NWORDS = 16,
    parameter int LEN_W  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        msg_valid,
    output logic        msg_ready,
    input  logic [31:0] msg_word,
    input  logic [2:0]  msg_bytes,
    input  logic        msg_last,
    input  logic        core_rdy,
    output logic        blk_start,
    output logic        word_valid,
    output logic [31:0] word_out,
    output logic        blk_first,
    output logic        msg_done
);
    typedef enum logic [2:0] {FILL, PAD, LEN, WAIT, EMIT, DRAIN} state_t;
    state_t state_q, state_d;
    logic [31:0] mem_q [NWORDS];
    logic [4:0] widx_q, widx_d;
    logic [3:0] eidx_q, eidx_d;
    logic [LEN_W-1:0] bitlen_q, bitlen_d;
    logic first_q, first_d, pend80_q, pend80_d, lastblk_q, lastblk_d, lenblk_q, lenblk_d;
    logic [31:0] word_out_q, word_out_d;
    logic word_valid_q, word_valid_d, blk_start_q, blk_start_d, blk_first_q, blk_first_d;
    logic msg_done_q, msg_done_d;
    logic we, len_we, xfer, tail;
    logic [3:0] wa;
    logic [31:0] wd;
    logic [2:0] nb;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            widx_q       <= '0;
            eidx_q       <= '0;
            bitlen_q     <= '0;
            first_q      <= 1'b1;
            pend80_q     <= 1'b0;
            lastblk_q    <= 1'b0;
            lenblk_q     <= 1'b0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            blk_start_q  <= 1'b0;
            blk_first_q  <= 1'b0;
            msg_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            eidx_q       <= eidx_d;
            bitlen_q     <= bitlen_d;
            first_q      <= first_d;
            pend80_q     <= pend80_d;
            lastblk_q    <= lastblk_d;
            lenblk_q     <= lenblk_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            blk_start_q  <= blk_start_d;
            blk_first_q  <= blk_first_d;
            msg_done_q   <= msg_done_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem_q[wa] <= wd;
        if (len_we) begin
            mem_q[14] <= bitlen_q[63:32];
            mem_q[15] <= bitlen_q[31:0];
        end
    end
    assign xfer = msg_valid && state_q == FILL;
    assign nb   = msg_bytes > 3'd4 ? 3'd4 : msg_bytes;
    assign tail = msg_last && nb != 3'd4;
    assign wa   = widx_q[3:0];
    always_comb begin
        state_d   = state_q;
        widx_d    = widx_q;
        eidx_d    = eidx_q;
        bitlen_d  = bitlen_q;
        first_d   = first_q;
        pend80_d  = pend80_q;
        lastblk_d = lastblk_q;
        lenblk_d  = lenblk_q;
        we        = 1'b0;
        len_we    = 1'b0;
        wd        = msg_word;
        case (state_q)
            FILL: if (xfer) begin
                we       = 1'b1;
                widx_d   = widx_q + 5'd1;
                wd       = tail ? (msg_word & ~(32'hFFFF_FFFF >> {nb, 3'b000})) | (32'h8000_0000 >> {nb, 3'b000}) : msg_word;
                bitlen_d = bitlen_q + (tail ? LEN_W'({nb, 3'b000}) : LEN_W'(32));
                pend80_d = msg_last && !tail;
                lenblk_d = tail && widx_q == 5'd15;
                state_d  = widx_q == 5'd15 ? WAIT : (msg_last ? PAD : FILL);
            end
            PAD: begin
                wd = pend80_q ? 32'h8000_0000 : 32'h0;
                // index 14 without a pending marker means the marker already sits at 13
                if (widx_q == 5'd14 && !pend80_q) state_d = LEN;
                else begin
                    we       = 1'b1;
                    widx_d   = widx_q + 5'd1;
                    pend80_d = 1'b0;
                    state_d  = widx_q == 5'd13 ? LEN : (widx_q == 5'd15 ? WAIT : PAD);
                    lenblk_d = lenblk_q || widx_q == 5'd15;
                end
            end
            LEN: begin
                len_we    = 1'b1;
                lastblk_d = 1'b1;
                state_d   = WAIT;
            end
            WAIT: if (first_q || core_rdy) begin
                state_d = EMIT;
                eidx_d  = '0;
            end
            EMIT: begin
                eidx_d = eidx_q + 4'd1;
                if (eidx_q == 4'd15) begin
                    first_d  = 1'b0;
                    widx_d   = '0;
                    lenblk_d = 1'b0;
                    state_d  = (pend80_q || lenblk_q) ? PAD : (lastblk_q ? DRAIN : FILL);
                end
            end
            DRAIN: if (core_rdy) begin
                first_d   = 1'b1;
                bitlen_d  = '0;
                lastblk_d = 1'b0;
                state_d   = FILL;
            end
            default: state_d = FILL;
        endcase
    end
    always_comb begin
        msg_ready    = state_q == FILL;
        word_valid_d = state_q == EMIT;
        word_out_d   = state_q == EMIT ? mem_q[eidx_q] : 32'h0;
        blk_start_d  = state_q == EMIT && eidx_q == 4'd0;
        blk_first_d  = state_q == EMIT && first_q;
        msg_done_d   = state_q == DRAIN && core_rdy;
    end
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign blk_start  = blk_start_q;
    assign blk_first  = blk_first_q;
    assign msg_done   = msg_done_q;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: directed padding scenarios with hand-computed SHA-256 blocks.
module tb_sha256_msg_padder;
    logic clk = 0, rst = 1, msg_valid = 0, msg_last = 0, core_rdy = 0;
    logic [31:0] msg_word = 0;
    logic [2:0] msg_bytes = 0;
    logic msg_ready, blk_start, word_valid, blk_first, msg_done;
    logic [31:0] word_out;
    int vectors = 0, miscompares = 0;
    logic [31:0] e [16];

    always #5 clk = ~clk;

    sha256_msg_padder #(.NWORDS(16), .LEN_W(64)) dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_word(msg_word), .msg_bytes(msg_bytes), .msg_last(msg_last),
        .core_rdy(core_rdy), .blk_start(blk_start), .word_valid(word_valid),
        .word_out(word_out), .blk_first(blk_first), .msg_done(msg_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] w, input logic [2:0] nb, input logic last);
        int t = 0;
        @(negedge clk);
        while (!msg_ready && t < 200) begin @(negedge clk); t++; end
        chk("send_ready", {31'b0, msg_ready}, 1);
        msg_valid = 1; msg_word = w; msg_bytes = nb; msg_last = last;
        @(negedge clk);
        msg_valid = 0; msg_last = 0;
    endtask

    task automatic get_block(input string tag, input logic [31:0] exp [16], input logic exp_first);
        int t = 0;
        @(negedge clk);
        while (!word_valid && t < 300) begin @(negedge clk); t++; end
        chk({tag, "_found"}, {31'b0, word_valid}, 1);
        chk({tag, "_start"}, {31'b0, blk_start}, 1);
        chk({tag, "_first"}, {31'b0, blk_first}, {31'b0, exp_first});
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("%s_w%0d", tag, i), word_out, exp[i]);
            if (i == 8) chk({tag, "_ready_low"}, {31'b0, msg_ready}, 0);
            if (i == 1) chk({tag, "_start_once"}, {31'b0, blk_start}, 0);
        end
        chk({tag, "_valid_w15"}, {31'b0, word_valid}, 1);
    endtask

    task automatic finish_msg(input string tag);
        int t = 0;
        core_rdy = 1;
        @(negedge clk);
        while (!msg_done && t < 100) begin @(negedge clk); t++; end
        chk({tag, "_done"}, {31'b0, msg_done}, 1);
        core_rdy = 0;
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'b0, msg_done}, 0);
        chk({tag, "_ready_after"}, {31'b0, msg_ready}, 1);
    endtask

    initial begin
        int seen;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, msg_ready}, 1);
        chk("rst_valid", {31'b0, word_valid}, 0);
        chk("rst_word", word_out, 0);
        chk("rst_start", {31'b0, blk_start}, 0);
        chk("rst_first", {31'b0, blk_first}, 0);
        chk("rst_done", {31'b0, msg_done}, 0);
        rst = 0;

        // "abc"
        e = '{default: 32'h0}; e[0] = 32'h6162_6380; e[15] = 32'h18;
        send(32'h6162_6300, 3'd3, 1);
        get_block("abc", e, 1);
        finish_msg("abc");

        // empty message, data bits must be masked away
        e = '{default: 32'h0}; e[0] = 32'h8000_0000;
        send(32'hFFFF_FFFF, 3'd0, 1);
        get_block("empty", e, 1);
        finish_msg("empty");

        // 55 bytes
        e = '{default: 32'h0};
        for (int i = 0; i < 13; i++) begin send(32'h1000_0000 + i, 3'd0, 0); e[i] = 32'h1000_0000 + i; end
        send(32'hAABB_CCDD, 3'd3, 1);
        e[13] = 32'hAABB_CC80; e[15] = 32'h1B8;
        get_block("b55", e, 1);
        finish_msg("b55");

        // 56 bytes, last byte count 5 behaves as 4
        e = '{default: 32'h0};
        for (int i = 0; i < 13; i++) begin send(32'h2000_0000 + i, 3'd0, 0); e[i] = 32'h2000_0000 + i; end
        send(32'h2000_000D, 3'd5, 1);
        e[13] = 32'h2000_000D; e[14] = 32'h8000_0000;
        get_block("b56_1", e, 1);
        seen = 0;
        repeat (30) begin @(negedge clk); if (word_valid) seen++; end
        chk("b56_hold", seen, 0);
        chk("b56_hold_ready", {31'b0, msg_ready}, 0);
        e = '{default: 32'h0}; e[15] = 32'h1C0;
        core_rdy = 1;
        get_block("b56_2", e, 0);
        finish_msg("b56");

        // 64 bytes
        e = '{default: 32'h0};
        for (int i = 0; i < 15; i++) begin send(32'h3000_0000 + i, 3'd0, 0); e[i] = 32'h3000_0000 + i; end
        send(32'h3000_000F, 3'd4, 1);
        e[15] = 32'h3000_000F;
        get_block("b64_1", e, 1);
        e = '{default: 32'h0}; e[0] = 32'h8000_0000; e[15] = 32'h200;
        core_rdy = 1;
        get_block("b64_2", e, 0);
        finish_msg("b64");

        // reset in the middle of an emission
        send(32'h6162_6300, 3'd3, 1);
        seen = 0;
        while (!word_valid && seen < 300) begin @(negedge clk); seen++; end
        chk("rst_mid_found", {31'b0, word_valid}, 1);
        repeat (6) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_valid", {31'b0, word_valid}, 0);
        chk("rst_mid_ready", {31'b0, msg_ready}, 1);
        rst = 0;
        e = '{default: 32'h0}; e[0] = 32'h6162_6380; e[15] = 32'h18;
        send(32'h6162_6300, 3'd3, 1);
        get_block("abc2", e, 1);
        finish_msg("abc2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
